// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_fetch_pkg;

  // Fetch FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  // Exception cause codes carried with a faulting packet
  localparam logic [3:0] IFU_EXC_MISALIGN = 4'd0;
  localparam logic [3:0] IFU_EXC_ACCESS   = 4'd1;

  // A fetch address must be 4-byte aligned
  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_inst_align.sv
// Selects the 32-bit instruction out of one memory read beat.
module ifu_inst_align #(
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] beat,
  output logic [INST_W-1:0] inst
);

  generate
    if (DATA_W == 2 * INST_W) begin : g_wide
      // Address bit 2 picks the upper or lower word of the beat
      always_comb inst = sel ? beat[DATA_W-1:INST_W] : beat[INST_W-1:0];
    end else begin : g_narrow
      logic unused_sel;
      assign unused_sel = sel;
      // The beat is exactly one instruction wide
      always_comb inst = beat[INST_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC handshake in, one AXI-lite read, packet out to decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              mem_arvalid_o,
  output logic [XLEN-1:0]   mem_araddr_o,
  input  logic              mem_arready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [1:0]        mem_rresp_i,
  output logic              mem_rready_o,
  output logic              if_valid_o,
  input  logic              if_ready_i,
  output logic [XLEN-1:0]   if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_exc_o,
  output logic [3:0]        if_exc_cause_o
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  ifu_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic              accept;
  logic              misalign;
  logic              resp_take;
  logic [INST_W-1:0] beat_inst;

  logic [XLEN-1:0]   pc_p0;
  logic [INST_W-1:0] inst_p1;
  logic              exc_p1;
  logic [3:0]        cause_p1;

  assign misalign = is_misaligned(pc_i[1:0]);

  ifu_inst_align #(
    .DATA_W (DATA_W),
    .INST_W (INST_W)
  ) u_align (
    .sel  (pc_p0[2]),
    .beat (mem_rdata_i),
    .inst (beat_inst)
  );

  // State register and the flag that marks a bus transaction whose result must be thrown away
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, handshake and bus control
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    pc_ready_o    = 1'b0;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    if_valid_o    = 1'b0;
    resp_take     = 1'b0;
    case (state_q)
      IDLE: begin
        pc_ready_o = !flush_i;
      end
      ADDR: begin
        // arvalid stays up until the slave takes it; a flush only poisons the result
        mem_arvalid_o = 1'b1;
        if (flush_i) drop_d = 1'b1;
        if (mem_arready_i) state_d = DATA;
      end
      DATA: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i) begin
          if (drop_q || flush_i) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            resp_take = 1'b1;
            state_d   = OUT;
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      OUT: begin
        if_valid_o = 1'b1;
        pc_ready_o = !flush_i && if_ready_i;
        if (flush_i || if_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = pc_valid_i && pc_ready_o;
    if (accept) state_d = misalign ? OUT : ADDR;
  end

  // Packet register: fetch PC on accept, instruction/exception on response; cleared on reset so outputs read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= '0;
      inst_p1  <= '0;
      exc_p1   <= 1'b0;
      cause_p1 <= '0;
    end else if (accept) begin
      pc_p0 <= pc_i;
      if (misalign) begin
        inst_p1  <= '0;
        exc_p1   <= 1'b1;
        cause_p1 <= IFU_EXC_MISALIGN;
      end
    end else if (resp_take) begin
      if (mem_rresp_i != 2'b00) begin
        inst_p1  <= '0;
        exc_p1   <= 1'b1;
        cause_p1 <= IFU_EXC_ACCESS;
      end else begin
        inst_p1  <= beat_inst;
        exc_p1   <= 1'b0;
        cause_p1 <= '0;
      end
    end
  end

  assign mem_araddr_o   = mem_arvalid_o ? {pc_p0[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign if_pc_o        = pc_p0;
  assign if_inst_o      = inst_p1;
  assign if_exc_o       = exc_p1;
  assign if_exc_cause_o = cause_p1;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: transaction-level model, memory responder, directed and random stimulus.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic [63:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        mem_arvalid_o;
  logic [63:0] mem_araddr_o;
  logic        mem_arready_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic [1:0]  mem_rresp_i;
  logic        mem_rready_o;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_exc_o;
  logic [3:0]  if_exc_cause_o;

  ifu_fetch #(.XLEN(64), .DATA_W(64), .INST_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .pc_valid_i     (pc_valid_i),
    .pc_ready_o     (pc_ready_o),
    .flush_i        (flush_i),
    .mem_arvalid_o  (mem_arvalid_o),
    .mem_araddr_o   (mem_araddr_o),
    .mem_arready_i  (mem_arready_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_rresp_i    (mem_rresp_i),
    .mem_rready_o   (mem_rready_o),
    .if_valid_o     (if_valid_o),
    .if_ready_i     (if_ready_i),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o),
    .if_exc_o       (if_exc_o),
    .if_exc_cause_o (if_exc_cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Outstanding-fetch record: at most one fetch lives between accept and retirement
  bit          m_busy = 0;
  logic [63:0] m_pc = '0;
  bit          m_mis = 0;       // misaligned: no bus access, packet ready at once
  bit          m_ar_done = 0;   // address handed to memory
  bit          m_bus_done = 0;  // data beat received
  bit          m_dead = 0;      // killed by a redirect
  logic [31:0] m_inst = '0;
  bit          m_exc = 0;
  logic [3:0]  m_cause = '0;

  // Memory responder state
  bit          r_pending = 0;
  int          r_cnt = 0;
  logic [63:0] r_addr = '0;
  logic [1:0]  r_resp = '0;

  // Stimulus knobs
  bit          k_beat_fix = 0;
  logic [63:0] k_beat = '0;
  bit          k_resp_rand = 0;
  logic [1:0]  k_resp = '0;
  int          k_delay = 0;     // negative: random latency
  bit          k_noise = 0;     // spurious rvalid while nothing is outstanding

  logic e_arvalid, e_rready, e_valid, e_pc_ready;
  logic [63:0] e_araddr;
  assign e_arvalid  = m_busy && !m_mis && !m_ar_done;
  assign e_rready   = m_busy && !m_mis && m_ar_done && !m_bus_done;
  assign e_valid    = m_busy && !m_dead && (m_mis || m_bus_done);
  assign e_pc_ready = !flush_i && (!m_busy || (e_valid && if_ready_i));
  assign e_araddr   = {m_pc[63:3], 3'b000};

  function automatic logic [63:0] beat_of(input logic [63:0] a);
    return {a[31:0] ^ a[63:32] ^ 32'h1357_9BDF, a[31:0] ^ 32'hCAFE_F00D};
  endfunction

  bit ar_hs, r_hs, consume, accept;

  // Model update at each active edge from the values the bench drove this cycle
  always @(posedge clk) begin
    if (rst) begin
      m_busy    = 0;
      r_pending = 0;
    end else begin
      ar_hs   = e_arvalid && mem_arready_i;
      r_hs    = e_rready && mem_rvalid_i;
      consume = e_valid && if_ready_i && !flush_i;
      accept  = pc_valid_i && e_pc_ready;
      if (r_pending) begin
        if (mem_rvalid_i) r_pending = 0;
        else if (r_cnt > 0) r_cnt--;
      end
      if (ar_hs) begin
        r_pending = 1;
        r_cnt     = (k_delay < 0) ? int'($urandom_range(0, 3)) : k_delay;
        r_addr    = e_araddr;
        r_resp    = k_resp_rand ? (($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00) : k_resp;
      end
      if (m_busy) begin
        if (flush_i) m_dead = 1;
        if (ar_hs) m_ar_done = 1;
        if (r_hs) begin
          m_bus_done = 1;
          if (mem_rresp_i != 2'b00) begin
            m_exc = 1; m_cause = 4'd1; m_inst = '0;
          end else begin
            m_exc = 0; m_cause = 4'd0;
            m_inst = m_pc[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
          end
        end
        if (m_dead && (m_mis || m_bus_done)) m_busy = 0;
        if (consume) m_busy = 0;
      end
      if (accept) begin
        m_busy = 1; m_pc = pc_i; m_mis = (pc_i[1:0] != 2'b00);
        m_ar_done = 0; m_bus_done = 0; m_dead = 0;
        if (m_mis) begin m_exc = 1; m_cause = 4'd0; m_inst = '0; end
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_ready", pc_ready_o, e_pc_ready);
      chk("arvalid", mem_arvalid_o, e_arvalid);
      if (e_arvalid) chk("araddr", mem_araddr_o, e_araddr);
      chk("rready", mem_rready_o, e_rready);
      chk("if_valid", if_valid_o, e_valid);
      if (e_valid) begin
        chk("if_pc", if_pc_o, m_pc);
        chk("if_inst", if_inst_o, m_inst);
        chk("if_exc", if_exc_o, m_exc);
        chk("if_cause", if_exc_cause_o, m_cause);
      end
    end
  end

  task automatic drive_bus();
    if (r_pending && r_cnt == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = k_beat_fix ? k_beat : beat_of(r_addr);
      mem_rresp_i  = r_resp;
    end else if (k_noise && !r_pending && $urandom_range(0, 3) == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = {$urandom, $urandom};
      mem_rresp_i  = 2'($urandom_range(0, 3));
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_rresp_i  = 2'b00;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_bus();
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  // Accept pc, walk through ADDR/DATA with zero-wait memory, stop at the cycle the packet shows
  task automatic fetch_to_out(input logic [63:0] pc, input logic [63:0] araddr_exp, input string tag);
    pc_i = pc; pc_valid_i = 1'b1;
    step(); pc_valid_i = 1'b0; peek();
    chk({tag, "_arvalid"}, mem_arvalid_o, 1'b1);
    chk({tag, "_araddr"}, mem_araddr_o, araddr_exp);
    step(); peek();
    chk({tag, "_valid_c2"}, if_valid_o, 1'b0);
    step(); peek();
    chk({tag, "_valid_c3"}, if_valid_o, 1'b1);
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; if_ready_i = 1'b0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rresp_i = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1; drive_bus();
    peek();
    chk("rst_pc_ready", pc_ready_o, 1'b1);
    chk("rst_arvalid", mem_arvalid_o, 1'b0);
    chk("rst_araddr", mem_araddr_o, 64'h0);
    chk("rst_rready", mem_rready_o, 1'b0);
    chk("rst_valid", if_valid_o, 1'b0);
    chk("rst_pc", if_pc_o, 64'h0);
    chk("rst_inst", if_inst_o, 32'h0);
    chk("rst_exc", if_exc_o, 1'b0);

    // Basic fetch, lower word
    step();
    if_ready_i = 1'b1; mem_arready_i = 1'b1;
    k_beat_fix = 1; k_beat = 64'h00000013_00100093; k_delay = 0; k_resp = 2'b00;
    fetch_to_out(64'h8000_0000, 64'h8000_0000, "basic");
    chk("basic_inst", if_inst_o, 32'h00100093);
    chk("basic_pc", if_pc_o, 64'h8000_0000);
    chk("basic_exc", if_exc_o, 1'b0);

    // Upper word of the same beat
    step();
    fetch_to_out(64'h8000_0004, 64'h8000_0000, "upper");
    chk("upper_inst", if_inst_o, 32'h00000013);

    // Misaligned PC: immediate exception packet, no bus access
    step();
    pc_i = 64'h8000_0002; pc_valid_i = 1'b1;
    step(); pc_valid_i = 1'b0; peek();
    chk("mis_arvalid", mem_arvalid_o, 1'b0);
    chk("mis_valid", if_valid_o, 1'b1);
    chk("mis_exc", if_exc_o, 1'b1);
    chk("mis_cause", if_exc_cause_o, 4'd0);
    chk("mis_inst", if_inst_o, 32'h0);

    // Access fault
    step();
    k_resp = 2'b10;
    fetch_to_out(64'h8000_0008, 64'h8000_0008, "fault");
    chk("fault_exc", if_exc_o, 1'b1);
    chk("fault_cause", if_exc_cause_o, 4'd1);
    chk("fault_inst", if_inst_o, 32'h0);

    // Flush while waiting for data; response lands 4 cycles after the flush
    step();
    k_resp = 2'b00; k_delay = 4;
    pc_i = 64'h8000_0010; pc_valid_i = 1'b1;
    step(); pc_valid_i = 1'b0;
    step(); flush_i = 1'b1; peek();
    chk("flush_rready", mem_rready_o, 1'b1);
    step(); flush_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      peek();
      chk("flush_novalid", if_valid_o, 1'b0);
      step();
    end
    peek();
    chk("flush_idle_ready", pc_ready_o, 1'b1);
    step();
    k_delay = 0;
    fetch_to_out(64'h8000_0100, 64'h8000_0100, "refetch");
    chk("refetch_inst", if_inst_o, 32'h00100093);
    chk("refetch_pc", if_pc_o, 64'h8000_0100);

    // Backpressure: packet held 5 cycles, no new accept
    step();
    if_ready_i = 1'b0;
    fetch_to_out(64'h8000_0004, 64'h8000_0000, "bp");
    chk("bp_inst", if_inst_o, 32'h00000013);
    for (int i = 0; i < 4; i++) begin
      step(); pc_i = 64'h8000_0040; pc_valid_i = 1'b1; peek();
      chk("bp_valid", if_valid_o, 1'b1);
      chk("bp_hold_inst", if_inst_o, 32'h00000013);
      chk("bp_hold_pc", if_pc_o, 64'h8000_0004);
      chk("bp_pc_ready", pc_ready_o, 1'b0);
    end
    step(); if_ready_i = 1'b1; pc_i = 64'h8000_0020; pc_valid_i = 1'b1; peek();
    chk("bp_release_ready", pc_ready_o, 1'b1);
    step(); pc_valid_i = 1'b0; mem_arready_i = 1'b0; peek();
    chk("addr_arvalid", mem_arvalid_o, 1'b1);
    chk("addr_araddr", mem_araddr_o, 64'h8000_0020);

    // Reset while in ADDR
    step(); rst = 1'b1;
    step(); rst = 1'b0; mem_arready_i = 1'b1; peek();
    chk("rst2_arvalid", mem_arvalid_o, 1'b0);
    chk("rst2_araddr", mem_araddr_o, 64'h0);
    chk("rst2_valid", if_valid_o, 1'b0);
    chk("rst2_rready", mem_rready_o, 1'b0);
    chk("rst2_pc", if_pc_o, 64'h0);
    chk("rst2_pc_ready", pc_ready_o, 1'b1);

    // Randomized traffic against the model
    k_beat_fix = 0; k_resp_rand = 1; k_delay = -1; k_noise = 1;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst        = ($urandom_range(0, 399) == 0);
      pc_valid_i = ($urandom_range(0, 99) < 70);
      pc_i       = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 15) begin
        if (pc_i[1:0] == 2'b00) pc_i[0] = 1'b1;
      end else begin
        pc_i[1:0] = 2'b00;
      end
      flush_i       = ($urandom_range(0, 99) < 6);
      if_ready_i    = ($urandom_range(0, 99) < 70);
      mem_arready_i = ($urandom_range(0, 99) < 60);
    end
    step();
    rst = 1'b0; pc_valid_i = 1'b0; flush_i = 1'b0;
    peek();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC module.
- Accepts the next instruction address from the PC module over a valid/ready handshake.
- Issues one read on an AXI-lite-style instruction-memory read channel and extracts the 32-bit instruction from the returned beat.
- Presents {pc, inst, exception} to the decode stage over a valid/ready handshake; supports pipeline flush (branch/trap redirect) with an in-flight response drop.

Parameters:
- XLEN, 64, address / PC width (matches `XLEN in sysconfig.v).
- DATA_W, 64, memory read-data width; legal values 32 or 64.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc_i  in  XLEN  next fetch address from PC module
- pc_valid_i  in  1  pc_i valid
- pc_ready_o  out  1  fetch stage accepts pc_i this cycle
- flush_i  in  1  redirect; kill current fetch and output
- mem_arvalid_o  out  1  read address valid
- mem_araddr_o  out  XLEN  read address, aligned to DATA_W/8
- mem_arready_i  in  1  read address accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_W  read data beat
- mem_rresp_i  in  2  response; nonzero = error
- mem_rready_o  out  1  read data accepted
- if_valid_o  out  1  instruction packet valid to decode
- if_ready_i  in  1  decode accepts packet
- if_pc_o  out  XLEN  PC of packet
- if_inst_o  out  INST_W  fetched instruction; 0 when if_exc_o=1
- if_exc_o  out  1  packet carries exception
- if_exc_cause_o  out  4  0 = instruction-address-misaligned, 1 = instruction-access-fault

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, drop=0.
  - All outputs 0, except pc_ready_o=1 in the cycle after reset.
  - Reset mid-transaction abandons it; a response arriving after reset is ignored because the block is in IDLE with rready=0.
- FSM states: IDLE, ADDR, DATA, OUT.
- pc_ready_o = !flush_i && (state==IDLE || (state==OUT && if_ready_i)).
- Accept event: pc_valid_i && pc_ready_o.
  - Latch pc_i.
  - If pc_i[1:0]!=0 → OUT with if_exc_o=1, cause 0, inst=0; no bus access.
  - Otherwise → ADDR.
- ADDR:
  - mem_arvalid_o=1, mem_araddr_o = pc with low log2(DATA_W/8) bits zeroed.
  - Once asserted, arvalid holds until mem_arready_i, even under flush.
  - On arready → DATA.
- DATA:
  - mem_rready_o=1.
  - On mem_rvalid_i, inst = beat slice selected by pc[2] (DATA_W=64), or the full beat (DATA_W=32).
  - mem_rresp_i!=0 → exc=1, cause 1, inst=0.
  - If drop or flush_i this cycle: discard, clear drop, → IDLE. Otherwise → OUT.
- OUT:
  - if_valid_o=1; packet is stable while !if_ready_i.
  - On if_ready_i: an accept in the same cycle goes directly to ADDR/OUT; otherwise → IDLE.
- Flush:
  - In IDLE/OUT: if_valid_o deasserted next cycle, → IDLE, no accept that cycle.
  - In ADDR/DATA: set drop; the transaction completes on the bus and its response is discarded.
  - Flush wins over simultaneous rvalid and over simultaneous if_ready_i; the packet counts as not consumed by decode.
- Latency: accept at cycle 0, arvalid at cycle 1, DATA at cycle 2; with zero-wait memory, if_valid_o at cycle 3.
- Throughput: at most one outstanding request; one instruction per 3 cycles best case.

Decomposition:
- sysconfig.v defines: FSM state encodings (2 bits), exception cause codes (IFU_EXC_MISALIGN=4'd0, IFU_EXC_ACCESS=4'd1), `XLEN_BUS reuse.
- One sub-module, ifu_inst_align: combinational beat-to-instruction slice, selected by pc and DATA_W.
- Everything else (FSM, drop flag, packet register) stays in ifu_fetch.

Test Plan:
- Basic fetch:
  - Stimulus: pc_i=0x80000000, zero-wait memory returning rdata=0x00000013_00100093.
  - Required: araddr=0x80000000; if_inst_o=0x00100093, if_pc_o=0x80000000, if_valid_o rises 3 cycles after accept.
- Upper-half select:
  - Stimulus: pc_i=0x80000004, same beat.
  - Required: if_inst_o=0x00000013; araddr=0x80000000.
- Misaligned:
  - Stimulus: pc_i=0x80000002.
  - Required: no arvalid ever; next cycle if_valid_o=1, if_exc_o=1, cause=0, inst=0.
- Access fault:
  - Stimulus: rresp=2'b10.
  - Required: if_exc_o=1, cause=1, if_inst_o=0.
- Flush during DATA:
  - Stimulus: flush_i pulsed while waiting, rvalid arrives 4 cycles later.
  - Required: no if_valid_o for that response; state returns to IDLE; next pc 0x80000100 is fetched normally.
- Backpressure plus reset:
  - Stimulus: hold if_ready_i=0 for 5 cycles in OUT.
  - Required: packet stable, pc_ready_o=0.
  - Stimulus: assert rst during ADDR.
  - Required: next cycle all outputs 0, arvalid=0.
